// File: rtl/bcd_7seg_scanner.sv
// rtl/bcd_7seg_scanner.sv - 3-digit multiplexed common-anode 7-segment scanner for BCD digits
// Latches hundreds/tens/ones on load and scans them at CLK_DIV cycles per digit slot.
module bcd_7seg_scanner #(
  parameter int CLK_DIV       = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic [6:0] seg,
  output logic [2:0] an
);

  localparam int CW = $clog2(CLK_DIV);

  localparam logic [1:0] SLOT_ONES = 2'd0;
  localparam logic [1:0] SLOT_TENS = 2'd1;
  localparam logic [1:0] SLOT_HUND = 2'd2;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_slot;
  logic [3:0]    r_hund;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [6:0]    r_seg;
  logic [2:0]    r_an;

  logic          w_tick;
  logic [1:0]    w_next_slot;
  logic [3:0]    w_digit;
  logic          w_blank;
  logic [2:0]    w_an_lit;

  // Active-high {g,f,e,d,c,b,a}; anything outside 0..9 renders as a dash.
  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h3F;
      4'd1:    enc = 7'h06;
      4'd2:    enc = 7'h5B;
      4'd3:    enc = 7'h4F;
      4'd4:    enc = 7'h66;
      4'd5:    enc = 7'h6D;
      4'd6:    enc = 7'h7D;
      4'd7:    enc = 7'h07;
      4'd8:    enc = 7'h7F;
      4'd9:    enc = 7'h6F;
      default: enc = 7'h40;
    endcase
  endfunction

  assign w_tick      = (r_cnt == CW'(CLK_DIV - 1));
  assign w_next_slot = (r_slot == SLOT_HUND) ? SLOT_ONES : r_slot + 2'd1;

  // Decode for the slot being entered, using the digits latched before this edge.
  always_comb begin
    w_digit  = r_hund;
    w_blank  = 1'b0;
    w_an_lit = 3'b011;
    case (w_next_slot)
      SLOT_ONES: begin
        w_digit  = r_ones;
        w_an_lit = 3'b110;
      end
      SLOT_TENS: begin
        w_digit  = r_tens;
        w_blank  = BLANK_LEADING && (r_hund == 4'd0) && (r_tens == 4'd0);
        w_an_lit = 3'b101;
      end
      default: begin
        w_digit  = r_hund;
        w_blank  = BLANK_LEADING && (r_hund == 4'd0);
        w_an_lit = 3'b011;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_slot <= SLOT_HUND;
      r_hund <= 4'd0;
      r_tens <= 4'd0;
      r_ones <= 4'd0;
      r_an   <= 3'b111;
      r_seg  <= 7'h7F;
    end else begin
      if (load) begin
        r_hund <= hundreds;
        r_tens <= tens;
        r_ones <= ones;
      end
      if (w_tick) begin
        r_cnt  <= '0;
        r_slot <= w_next_slot;
        r_an   <= w_blank ? 3'b111 : w_an_lit;
        r_seg  <= w_blank ? 7'h7F : ~enc(w_digit);
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: doc/bcd_7seg_scanner.md
Name: bcd_7seg_scanner

Overview:
Consumes the three BCD digits (hundreds, tens, ones) produced by the binary-to-BCD converter. Drives a 3-digit multiplexed common-anode 7-segment display. Digits are captured on a load strobe and scanned one at a time at a divided refresh rate, with leading-zero blanking and an invalid-digit indicator. It sits between the converter and the board display pins.

Parameters:
CLK_DIV, 50000, clk cycles per digit slot; minimum 2; prescaler width is $clog2(CLK_DIV).
BLANK_LEADING, 1, 1 = suppress leading zeros in hundreds/tens; 0 = always show all three digits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
load  input  1  capture hundreds/tens/ones at this rising edge
hundreds  input  4  BCD hundreds digit
tens  input  4  BCD tens digit
ones  input  4  BCD ones digit
seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered
an  output  3  digit enables, active-low, registered; an[0]=ones, an[1]=tens, an[2]=hundreds

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (asserted):
  - prescaler = 0, slot index = 2 (hundreds), latched digits = 0.
  - an = 3'b111 and seg = 7'h7F (all off).
- Load: when load=1 at an edge, the latched digits take the input values at that edge. Inputs are ignored while load=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick = (count == CLK_DIV-1).
  - The first tick after reset release occurs on the CLK_DIV-th edge.
- Slot sequence: on each tick, the slot advances 2→0→1→2 (ones, tens, hundreds). At that same edge, an/seg are registered for the new slot, so outputs change exactly at tick edges and hold for CLK_DIV cycles. Full scan period = 3*CLK_DIV.
- Output source: an/seg are computed from the latched digits as they were before the edge. If load and tick coincide, that slot shows the old value and the new value appears from the next tick.
- Segment encoding, active-high before inversion:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Digit values 10..15 display a dash (40).
  - seg = ~encoding.
- Active slot: exactly one an bit is low, unless that slot is blanked. A blanked slot drives an = 3'b111 and seg = 7'h7F.
- Blanking (BLANK_LEADING=1):
  - hundreds slot blanked iff latched hundreds == 0.
  - tens slot blanked iff latched hundreds == 0 and latched tens == 0.
  - ones is never blanked, so value 0 shows "0".
  - An invalid digit (>9) is not zero: it is shown as a dash and does not cause blanking.
- Reset mid-scan: outputs go off immediately, asynchronously. The scan restarts from the reset state and the latched digits are lost (zero).
- No combinational path from any input to seg/an.

Test Plan:
- Reset (CLK_DIV=4): rst_n=0 → an=111, seg=7F. Release, no load → an=110, seg=40 ("0") after the 4th edge. Tens and hundreds slots are blank (an=111, seg=7F). Each slot lasts 4 cycles.
- Load h=2, t=4, o=9 → the following ticks show, in order:
  - ones: an=110, seg=10.
  - tens: an=101, seg=19.
  - hundreds: an=011, seg=24.
  - The pattern repeats every 12 cycles.
- Blanking:
  - Load 0,5,1 → hundreds slot an=111; tens seg=12; ones seg=79.
  - Load 0,0,7 → only the ones slot lights, seg=78.
  - With BLANK_LEADING=0, load 0,0,7 → hundreds and tens show seg=40.
- Invalid digit: load h=0, t=C, o=3 → tens slot seg=3F (dash, not blanked); hundreds slot blanked.
- Load coincident with tick, changing 1,1,1 to 2,2,2 → the slot entered at that edge shows seg=79 ("1"); the next tick shows seg=24 ("2").
- Async reset mid-slot with no clk edge → an=111, seg=7F within the same cycle. After release, digits read 0 and the first tick comes after CLK_DIV edges.
